ase_tx_scheduler: RTL and testbench

//  Round-robin scheduler sharing one ASE TX request channel between NUM_REQ requesters.

---
 rtl/ase_pkg.sv | 33 +++
 rtl/ase_tx_scheduler_if.sv | 33 +++
 rtl/ase_rr_picker.sv | 33 +++
 rtl/ase_tx_scheduler.sv | 116 +++++++++++
 tb/tb_ase_tx_scheduler.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ase_pkg.sv
// Shared ASE TX channel types: request header layout, request types and scheduler states.
package ase_pkg;

  typedef enum logic [3:0] {
    ASE_WRLINE_I = 4'h0,
    ASE_WRLINE_M = 4'h1,
    ASE_WRPUSH_I = 4'h2,
    ASE_WRFENCE  = 4'h4,
    ASE_RDLINE_S = 4'h8,
    ASE_RDLINE_I = 4'h9
  } ase_reqtype_t;

  typedef struct packed {
    logic [5:0]   rsvd;
    logic [1:0]   vc_sel;
    logic [1:0]   cl_len;
    ase_reqtype_t reqtype;
    logic [41:0]  addr;
    logic [15:0]  mdata;
  } TxHdr_t;

  localparam int unsigned CCIP_TX_HDR_WIDTH = $bits(TxHdr_t);

  typedef enum logic {
    SCH_ARB,
    SCH_DRAIN
  } sched_state_t;

  function automatic logic is_wrfence(TxHdr_t hdr);
    return hdr.reqtype == ASE_WRFENCE;
  endfunction

endpackage

// File: rtl/ase_tx_scheduler_if.sv
// Request/response bundle between AFU-side requesters, the TX scheduler and the TX channel.
interface ase_tx_scheduler_if #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned TID_WIDTH       = 32,
  parameter int unsigned MAX_OUTSTANDING = 64
);
  import ase_pkg::*;

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_REQ-1:0]   req_valid;
  TxHdr_t [NUM_REQ-1:0] req_hdr;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 out_valid;
  TxHdr_t               out_hdr;
  logic [TID_WIDTH-1:0] out_tid;
  logic                 out_ready;
  logic                 rsp_valid;
  logic [CNT_W-1:0]     outstanding;
  logic                 fence_active;
  logic                 err_underflow;

  modport master (
    output req_valid, req_hdr, out_ready, rsp_valid,
    input  req_ready, out_valid, out_hdr, out_tid, outstanding, fence_active, err_underflow
  );

  modport slave (
    input  req_valid, req_hdr, out_ready, rsp_valid,
    output req_ready, out_valid, out_hdr, out_tid, outstanding, fence_active, err_underflow
  );

endinterface

// File: rtl/ase_rr_picker.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
module ase_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    cand    = '0;
    found   = 1'b0;
    // NUM_REQ is a power of two, so the index adder wraps naturally.
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = rr_ptr_i + IDX_W'(i);
      if (!found && valid_i[cand]) begin
        found = 1'b1;
        idx_o = cand;
      end
    end
    if (found) grant_o[idx_o] = 1'b1;
    any_o = found;
  end

endmodule

// File: rtl/ase_tx_scheduler.sv
// Round-robin TX request scheduler with tid stamping, credit limit and WrFence drain.
module ase_tx_scheduler
  import ase_pkg::*;
#(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned TID_WIDTH       = 32,
  parameter int unsigned MAX_OUTSTANDING = 64
) (
  input logic               clk,
  input logic               rst,
  ase_tx_scheduler_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned SEQ_W = TID_WIDTH - IDX_W;
  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUTSTANDING);

  sched_state_t         state_q, state_d;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [SEQ_W-1:0]     seq_q [NUM_REQ];
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, underflow;
  logic                 out_valid_q;
  TxHdr_t               out_hdr_q;
  logic [TID_WIDTH-1:0] out_tid_q;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 load_ok, grant_en, grant_fence;

  ase_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .valid_i  (bus.req_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (pick_grant),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  assign load_ok = !out_valid_q || bus.out_ready;
  // Gated by rst so no requester sees an accept while reset is held.
  assign grant_en = !rst && (state_q == SCH_ARB) && load_ok && (cnt_q < MaxCnt) && pick_any;
  assign grant_fence = grant_en && is_wrfence(bus.req_hdr[pick_idx]);

  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    case ({grant_en, bus.rsp_valid})
      2'b10: cnt_d = cnt_q + CNT_W'(1);
      2'b01: begin
        if (cnt_q == '0) underflow = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCH_ARB:   if (grant_fence) state_d = SCH_DRAIN;
      SCH_DRAIN: if (cnt_q == '0 && !out_valid_q) state_d = SCH_ARB;
      default:   state_d = SCH_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= SCH_ARB;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (underflow) err_q <= 1'b1;
      if (grant_en) rr_ptr_q <= pick_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) seq_q[i] <= '0;
    end else if (grant_en) begin
      seq_q[pick_idx] <= seq_q[pick_idx] + SEQ_W'(1);
    end
  end

  // Output register holds its contents whenever nothing new is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_hdr_q   <= '0;
      out_tid_q   <= '0;
    end else if (grant_en) begin
      out_valid_q <= 1'b1;
      out_hdr_q   <= bus.req_hdr[pick_idx];
      out_tid_q   <= {seq_q[pick_idx], pick_idx};
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.req_ready     = grant_en ? pick_grant : '0;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_hdr       = out_hdr_q;
  assign bus.out_tid       = out_tid_q;
  assign bus.outstanding   = cnt_q;
  assign bus.fence_active  = (state_q == SCH_DRAIN);
  assign bus.err_underflow = err_q;

endmodule

// File: tb/tb_ase_tx_scheduler.sv
// Directed bench for ase_tx_scheduler: a 64-credit instance and a 4-credit instance share stimulus.
module tb_ase_tx_scheduler;
  import ase_pkg::*;

  logic           clk;
  logic           rst;
  logic [3:0]     req_valid;
  TxHdr_t [3:0]   req_hdr;
  logic           out_ready;
  logic           rsp_valid;

  int n_checks;
  int n_errors;

  ase_tx_scheduler_if #(.NUM_REQ(4), .TID_WIDTH(32), .MAX_OUTSTANDING(64)) bus ();
  ase_tx_scheduler_if #(.NUM_REQ(4), .TID_WIDTH(32), .MAX_OUTSTANDING(4))  bus_s ();

  assign bus.req_valid   = req_valid;
  assign bus.req_hdr     = req_hdr;
  assign bus.out_ready   = out_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus_s.req_valid = req_valid;
  assign bus_s.req_hdr   = req_hdr;
  assign bus_s.out_ready = out_ready;
  assign bus_s.rsp_valid = rsp_valid;

  ase_tx_scheduler #(.NUM_REQ(4), .TID_WIDTH(32), .MAX_OUTSTANDING(64)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ase_tx_scheduler #(.NUM_REQ(4), .TID_WIDTH(32), .MAX_OUTSTANDING(4)) u_dut_small (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic TxHdr_t mk_hdr(ase_reqtype_t rt, logic [15:0] md);
    TxHdr_t h;
    h         = '0;
    h.reqtype = rt;
    h.mdata   = md;
    return h;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_hdrs();
    for (int i = 0; i < 4; i++) req_hdr[i] = mk_hdr(ASE_RDLINE_S, 16'(32'h100 + i));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    rsp_valid = 1'b0;
    set_hdrs();
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    rsp_valid = 1'b0;
    set_hdrs();
    #1;
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check_eq("rst_out_tid", bus.out_tid, 32'h0);
    check_eq("rst_out_hdr", 32'(bus.out_hdr.mdata), 32'h0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'h0);
    check_eq("rst_outstanding", 32'(bus.outstanding), 32'h0);
    check_eq("rst_fence", 32'(bus.fence_active), 32'h0);
    check_eq("rst_err", 32'(bus.err_underflow), 32'h0);

    // Round robin across all four requesters, no backpressure.
    do_reset();
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      check_eq("rr_ready", 32'(bus.req_ready), 32'(1 << (k % 4)));
      tick();
      check_eq("rr_out_valid", 32'(bus.out_valid), 32'h1);
      check_eq("rr_tid", bus.out_tid, 32'(((k / 4) << 2) | (k % 4)));
      check_eq("rr_hdr", 32'(bus.out_hdr.mdata), 32'(32'h100 + (k % 4)));
      check_eq("rr_outstanding", 32'(bus.outstanding), 32'(k + 1));
    end

    // Downstream stall holds the output register and blocks new grants.
    do_reset();
    req_valid  = 4'b0100;
    req_hdr[2] = mk_hdr(ASE_WRLINE_I, 16'h22);
    out_ready  = 1'b0;
    #1;
    check_eq("stall_first_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check_eq("stall_first_tid", bus.out_tid, 32'h2);
    for (int k = 0; k < 3; k++) begin
      check_eq("stall_ready", 32'(bus.req_ready), 32'h0);
      check_eq("stall_valid", 32'(bus.out_valid), 32'h1);
      check_eq("stall_tid", bus.out_tid, 32'h2);
      check_eq("stall_hdr", 32'(bus.out_hdr.mdata), 32'h22);
      tick();
    end
    check_eq("stall_hold_tid", bus.out_tid, 32'h2);
    out_ready = 1'b1;
    #1;
    check_eq("resume_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check_eq("resume_valid", 32'(bus.out_valid), 32'h1);
    check_eq("resume_tid", bus.out_tid, 32'h6);
    req_valid = '0;
    #1;
    check_eq("idle_ready", 32'(bus.req_ready), 32'h0);
    tick();
    check_eq("idle_valid", 32'(bus.out_valid), 32'h0);

    // Credit limit of four on the small instance.
    do_reset();
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      check_eq("cr_ready", 32'(bus_s.req_ready), 32'(1 << k));
      tick();
      check_eq("cr_tid", bus_s.out_tid, 32'(k));
    end
    check_eq("cr_full_cnt", 32'(bus_s.outstanding), 32'h4);
    check_eq("cr_full_ready", 32'(bus_s.req_ready), 32'h0);
    tick();
    check_eq("cr_drained_valid", 32'(bus_s.out_valid), 32'h0);
    check_eq("cr_still_full", 32'(bus_s.req_ready), 32'h0);
    rsp_valid = 1'b1;
    #1;
    check_eq("cr_rsp_same_cycle", 32'(bus_s.req_ready), 32'h0);
    tick();
    check_eq("cr_after_rsp_cnt", 32'(bus_s.outstanding), 32'h3);
    rsp_valid = 1'b0;
    #1;
    check_eq("cr_regrant_ready", 32'(bus_s.req_ready), 32'h1);
    tick();
    check_eq("cr_regrant_cnt", 32'(bus_s.outstanding), 32'h4);
    check_eq("cr_regrant_tid", bus_s.out_tid, 32'h4);
    check_eq("cr_regrant_valid", 32'(bus_s.out_valid), 32'h1);
    check_eq("cr_refull_ready", 32'(bus_s.req_ready), 32'h0);

    // WrFence after two outstanding reads: drain three credits, then arbitrate again.
    do_reset();
    req_hdr[2] = mk_hdr(ASE_WRFENCE, 16'h102);
    req_valid  = 4'b0011;
    out_ready  = 1'b1;
    #1;
    tick();
    tick();
    check_eq("fe_pre_cnt", 32'(bus.outstanding), 32'h2);
    req_valid = 4'b0100;
    #1;
    check_eq("fe_grant_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check_eq("fe_active", 32'(bus.fence_active), 32'h1);
    check_eq("fe_cnt", 32'(bus.outstanding), 32'h3);
    check_eq("fe_tid", bus.out_tid, 32'h2);
    check_eq("fe_reqtype", 32'(bus.out_hdr.reqtype), 32'(ASE_WRFENCE));
    req_valid = 4'b0011;
    #1;
    check_eq("fe_block", 32'(bus.req_ready), 32'h0);
    for (int k = 0; k < 3; k++) begin
      rsp_valid = 1'b1;
      #1;
      check_eq("fe_drain_ready", 32'(bus.req_ready), 32'h0);
      tick();
      check_eq("fe_drain_cnt", 32'(bus.outstanding), 32'(2 - k));
      check_eq("fe_drain_active", 32'(bus.fence_active), 32'h1);
    end
    rsp_valid = 1'b0;
    check_eq("fe_out_empty", 32'(bus.out_valid), 32'h0);
    #1;
    check_eq("fe_last_block", 32'(bus.req_ready), 32'h0);
    tick();
    check_eq("fe_released", 32'(bus.fence_active), 32'h0);
    check_eq("fe_post_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check_eq("fe_post_tid", bus.out_tid, 32'h4);

    // Response with no credits outstanding.
    do_reset();
    check_eq("uf_before", 32'(bus.err_underflow), 32'h0);
    rsp_valid = 1'b1;
    tick();
    check_eq("uf_set", 32'(bus.err_underflow), 32'h1);
    check_eq("uf_cnt", 32'(bus.outstanding), 32'h0);
    rsp_valid = 1'b0;
    tick();
    tick();
    check_eq("uf_sticky", 32'(bus.err_underflow), 32'h1);
    check_eq("uf_cnt_hold", 32'(bus.outstanding), 32'h0);

    // Asynchronous reset mid-stream.
    do_reset();
    req_valid = 4'hF;
    out_ready = 1'b1;
    #1;
    repeat (5) tick();
    check_eq("ar_pre_cnt", 32'(bus.outstanding), 32'h5);
    check_eq("ar_pre_valid", 32'(bus.out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("ar_valid", 32'(bus.out_valid), 32'h0);
    check_eq("ar_tid", bus.out_tid, 32'h0);
    check_eq("ar_hdr", 32'(bus.out_hdr.mdata), 32'h0);
    check_eq("ar_cnt", 32'(bus.outstanding), 32'h0);
    check_eq("ar_ready", 32'(bus.req_ready), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("ar_first_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check_eq("ar_first_valid", 32'(bus.out_valid), 32'h1);
    check_eq("ar_first_tid", bus.out_tid, 32'h0);
    check_eq("ar_first_hdr", 32'(bus.out_hdr.mdata), 32'h100);
    check_eq("ar_first_cnt", 32'(bus.outstanding), 32'h1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
